// File: rtl/map_write_arbiter.sv
// Round-robin owner of the single map-RAM write port. For each granted sprite move it
// erases the current cell, draws the next cell, and then pulses done to that requester.
module map_write_arbiter #(
    parameter int NREQ       = 4,
    parameter int DATA_W     = 4,
    parameter int X_W        = 6,
    parameter int Y_W        = 5,
    parameter int MAP_W      = 40,
    parameter int MAP_H      = 30,
    parameter int ERASE_CODE = 0
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*X_W-1:0]      curr_x,
    input  logic [NREQ*Y_W-1:0]      curr_y,
    input  logic [NREQ*X_W-1:0]      next_x,
    input  logic [NREQ*Y_W-1:0]      next_y,
    input  logic [NREQ*DATA_W-1:0]   sprite,
    input  logic                     ram_ready,
    output logic                     wr_en,
    output logic [X_W+Y_W-1:0]       wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    output logic [NREQ-1:0]          done,
    output logic                     busy,
    output logic [2:0]               grant_id
);

    typedef enum logic [1:0] {IDLE, ERASE, DRAW, ACK} state_t;

    localparam logic [X_W:0]      MAP_W_L = MAP_W[X_W:0];
    localparam logic [Y_W:0]      MAP_H_L = MAP_H[Y_W:0];
    localparam logic [DATA_W-1:0] ERASE_L = ERASE_CODE[DATA_W-1:0];
    localparam logic [2:0]        LAST_ID = 3'(NREQ - 1);

    state_t              state, state_next;
    logic [2:0]          rr_ptr;
    logic [X_W-1:0]      lat_cx, lat_nx, sel_cx, sel_nx;
    logic [Y_W-1:0]      lat_cy, lat_ny, sel_cy, sel_ny;
    logic [DATA_W-1:0]   lat_spr, sel_spr;
    logic                req_any;
    logic                hi_found, lo_found;
    logic [2:0]          hi_idx, lo_idx, gnt_idx;
    logic                curr_in_map, next_in_map;
    logic                take_grant;

    assign req_any    = |req;
    assign take_grant = (state == IDLE) && req_any;

    // Two ascending scans: first set bit at or above rr_ptr, else first set bit overall (wrap).
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (req[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = 3'(i);
            end
            if (req[i] && !hi_found && (3'(i) >= rr_ptr)) begin
                hi_found = 1'b1;
                hi_idx   = 3'(i);
            end
        end
        gnt_idx = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        sel_cx  = '0;
        sel_cy  = '0;
        sel_nx  = '0;
        sel_ny  = '0;
        sel_spr = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (3'(i) == gnt_idx) begin
                sel_cx  = curr_x[i*X_W +: X_W];
                sel_cy  = curr_y[i*Y_W +: Y_W];
                sel_nx  = next_x[i*X_W +: X_W];
                sel_ny  = next_y[i*Y_W +: Y_W];
                sel_spr = sprite[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_any) state_next = ERASE;
            ERASE:   if (ram_ready) state_next = DRAW;
            DRAW:    if (ram_ready) state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            rr_ptr   <= '0;
            grant_id <= '0;
            lat_cx   <= '0;
            lat_cy   <= '0;
            lat_nx   <= '0;
            lat_ny   <= '0;
            lat_spr  <= '0;
        end else if (take_grant) begin
            rr_ptr   <= (gnt_idx == LAST_ID) ? 3'd0 : gnt_idx + 3'd1;
            grant_id <= gnt_idx;
            lat_cx   <= sel_cx;
            lat_cy   <= sel_cy;
            lat_nx   <= sel_nx;
            lat_ny   <= sel_ny;
            lat_spr  <= sel_spr;
        end
    end

    // Off-map cells still walk through their phase but never strobe the RAM.
    assign curr_in_map = ({1'b0, lat_cx} < MAP_W_L) && ({1'b0, lat_cy} < MAP_H_L);
    assign next_in_map = ({1'b0, lat_nx} < MAP_W_L) && ({1'b0, lat_ny} < MAP_H_L);

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        case (state)
            ERASE: begin
                wr_addr = {lat_cy, lat_cx};
                wr_data = ERASE_L;
                wr_en   = ram_ready && curr_in_map;
            end
            DRAW: begin
                wr_addr = {lat_ny, lat_nx};
                wr_data = lat_spr;
                wr_en   = ram_ready && next_in_map;
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase
    end

    always_comb begin
        done = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            done[i] = (state == ACK) && (grant_id == 3'(i));
        end
    end

    assign busy = (state != IDLE);

endmodule
